branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Control block that owns the branch comparator in the 16-bit core and sequences every branch through it. It accepts one branch request at a time over a valid/ready handshake and registers the operands. It drives the comparator for one evaluation cycle, then computes the target PC. For a taken branch it holds a redirect to fetch until fetch accepts it, and then asserts a pipeline flush for a fixed number of cycles.

## Interface
- DataWidth, 16: operand width of BrFirst/BrSecond and the comparator inputs.
- AddrWidth, 16: PC, offset and target width.
- FlushCycles, 2: cycles Flush stays high after a redirect is accepted; legal range 1..15.
- CLK  in  1  clock, all state changes on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- BrValid  in  1  branch request valid.
- BrReady  out  1  sequencer can accept a request.
- BrOPCode  in  3  branch opcode.
- BrFirst, BrSecond  in  DataWidth  compare operands.
- BrPC  in  AddrWidth  PC of the branch instruction.
- BrOffset  in  AddrWidth  two's-complement branch offset.
- CmpFirstInput, CmpSecondInput  out  DataWidth  comparator operands.
- CmpOPCode  out  3  comparator opcode.
- CmpResult  in  1  comparator result, combinational from Cmp* outputs.
- Resolved  out  1  one-cycle pulse when a branch is decided.
- Taken  out  1  branch outcome, valid while Resolved is high.
- RedirectValid  out  1  new fetch PC offered.
- RedirectPC  out  AddrWidth  target PC.
- FetchReady  in  1  fetch accepts the redirect.
- Flush  out  1  squash younger pipeline stages.
- TakenCount  out  16  number of taken branches, wraps modulo 2^16.

## Operation
- States: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE: BrReady=1. On BrValid, register BrOPCode/BrFirst/BrSecond/BrPC/BrOffset into the Cmp* output registers and internal registers, then go to EVAL. All other outputs are 0.
- EVAL: BrReady=0. Cmp* outputs are stable. Sample CmpResult at the end of the cycle; it defines the outcome, and the opcode is never re-evaluated locally.
- Comparator semantics are fixed: opcode 6–7 are unconditional (CmpResult=1); otherwise bit0=0 means equal and bit0=1 means unsigned less-than.
- Target computation:
  - Opcode 7: target = BrFirst (register jump, truncated or zero-extended to AddrWidth).
  - All other opcodes: target = BrPC + BrOffset modulo 2^AddrWidth (wraps, no overflow flag).
- EVAL → REDIRECT when CmpResult=1; EVAL → IDLE when CmpResult=0.
- On leaving EVAL, Resolved=1 for exactly one cycle with Taken=CmpResult. TakenCount increments on the same edge when taken.
- REDIRECT: RedirectValid=1 and RedirectPC=target, both held stable until FetchReady=1 is sampled. On that edge go to FLUSH, loading the flush counter with FlushCycles.
- FLUSH: Flush=1; the counter decrements each cycle. At count 1, return to IDLE on the next edge. Flush is high for exactly FlushCycles cycles.
- Cmp* outputs hold their last loaded values outside EVAL; they change only on acceptance in IDLE.
- BrValid while not IDLE is ignored; the requester must hold it until BrReady.
- RST_N low at any time: immediately enter IDLE. All outputs go to 0 except BrReady, which is 1 after reset. TakenCount=0, counters cleared, any pending redirect or flush abandoned.

## Timing
- Request accepted on edge N (BrValid & BrReady).
- EVAL occupies cycle N..N+1, with Cmp* valid from edge N.
- Resolved/Taken high in the cycle after edge N+1.
- Not-taken: BrReady returns high in the same cycle as Resolved. A back-to-back request can be accepted every 2 cycles.
- Taken: RedirectValid is high from edge N+1, concurrent with Resolved.
  - If FetchReady is already high, Flush is high from edge N+2 for FlushCycles cycles.
  - BrReady is high again at edge N+2+FlushCycles.
- FetchReady low: RedirectValid and RedirectPC hold indefinitely; no timeout.
- FetchReady outside REDIRECT has no effect.
- The async reset assertion clears state without a clock. Deassertion is synchronous to CLK by the system reset block; the first acceptance is possible on the first edge after release.

## Test plan
- Not-taken branch: opcode 0, First=0x1234, Second=0x1235, CmpResult=0 → Resolved pulse with Taken=0, no RedirectValid/Flush, TakenCount stays 0, BrReady high 2 cycles after acceptance.
- Taken with wrap-around: opcode 1, First=3, Second=7, PC=0xFFF0, Offset=0x0020, FetchReady=1 → RedirectPC=0x0010, Flush high exactly 2 cycles, TakenCount=1.
- Redirect stall: opcode 6, PC=0x0100, Offset=0xFFFC, FetchReady low for 5 cycles → RedirectValid and RedirectPC=0x00FC stable for 6 cycles; Flush starts only after FetchReady=1.
- Register jump: opcode 7, First=0xBEEF → RedirectPC=0xBEEF regardless of PC/Offset.
- Reset mid-operation: RST_N low during REDIRECT and during FLUSH → all outputs 0 and BrReady=1 immediately, with no clock edge; TakenCount=0.
- Counter wrap and back-to-back: preload 65535 taken branches, issue one more → TakenCount=0. BrValid held high across a not-taken branch is accepted again exactly 2 cycles later.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Branch-request, comparator, resolution and fetch-redirect signals of the branch sequencer.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; the
// offering side holds valid and its payload stable until then, and ready never depends on valid.
interface branch_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  br_valid;
    logic                  br_ready;
    logic [2:0]            br_opcode;
    logic [DATA_WIDTH-1:0] br_first;
    logic [DATA_WIDTH-1:0] br_second;
    logic [ADDR_WIDTH-1:0] br_pc;
    logic [ADDR_WIDTH-1:0] br_offset;

    logic [DATA_WIDTH-1:0] cmp_first;
    logic [DATA_WIDTH-1:0] cmp_second;
    logic [2:0]            cmp_opcode;
    logic                  cmp_result;

    logic                  resolved;
    logic                  taken;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  fetch_ready;
    logic                  flush;
    logic [15:0]           taken_count;

    // master: requester, comparator and fetch unit; slave: the sequencer itself
    modport master (
        output br_valid, br_opcode, br_first, br_second, br_pc, br_offset,
        output cmp_result, fetch_ready,
        input  br_ready, cmp_first, cmp_second, cmp_opcode,
        input  resolved, taken, redirect_valid, redirect_pc, flush, taken_count
    );

    modport slave (
        input  br_valid, br_opcode, br_first, br_second, br_pc, br_offset,
        input  cmp_result, fetch_ready,
        output br_ready, cmp_first, cmp_second, cmp_opcode,
        output resolved, taken, redirect_valid, redirect_pc, flush, taken_count
    );
endinterface

// File: rtl/branch_sequencer.sv
// Sequences one branch at a time through the external comparator, resolves it, and on a
// taken branch redirects fetch and then holds a pipeline flush for FLUSH_CYCLES cycles.
module branch_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_sequencer_if.slave bif,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] offset_q;
    logic [ADDR_WIDTH-1:0] target;
    logic [3:0]            flush_cnt;
    logic [15:0]           taken_count_q;
    logic                  accept;

    // br_ready is registered and only ever high in IDLE, so it alone qualifies acceptance
    assign accept          = bif.br_valid && bif.br_ready;
    assign state_dbg       = state;
    assign bif.taken_count = taken_count_q;

    // Register jump takes the first operand; everything else is PC-relative and wraps
    always_comb begin
        target = pc_q + offset_q;
        if (bif.cmp_opcode == 3'd7) begin
            target = ADDR_WIDTH'(bif.cmp_first);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            bif.br_ready       <= 1'b1;
            bif.cmp_first      <= '0;
            bif.cmp_second     <= '0;
            bif.cmp_opcode     <= '0;
            bif.resolved       <= 1'b0;
            bif.taken          <= 1'b0;
            bif.redirect_valid <= 1'b0;
            bif.redirect_pc    <= '0;
            bif.flush          <= 1'b0;
            pc_q               <= '0;
            offset_q           <= '0;
            flush_cnt          <= '0;
            taken_count_q      <= '0;
        end else begin
            bif.resolved <= 1'b0;
            bif.taken    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bif.cmp_first  <= bif.br_first;
                        bif.cmp_second <= bif.br_second;
                        bif.cmp_opcode <= bif.br_opcode;
                        pc_q           <= bif.br_pc;
                        offset_q       <= bif.br_offset;
                        bif.br_ready   <= 1'b0;
                        state          <= EVAL;
                    end
                end
                EVAL: begin
                    // The comparator's answer is the outcome; the opcode is not re-decoded here
                    bif.resolved <= 1'b1;
                    bif.taken    <= bif.cmp_result;
                    if (bif.cmp_result) begin
                        bif.redirect_valid <= 1'b1;
                        bif.redirect_pc    <= target;
                        taken_count_q      <= taken_count_q + 16'd1;
                        state              <= REDIRECT;
                    end else begin
                        bif.br_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (bif.fetch_ready) begin
                        bif.redirect_valid <= 1'b0;
                        bif.redirect_pc    <= '0;
                        bif.flush          <= 1'b1;
                        flush_cnt          <= 4'(FLUSH_CYCLES);
                        state              <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        bif.flush    <= 1'b0;
                        flush_cnt    <= '0;
                        bif.br_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a comparator model drives cmp_result, a scoreboard
// queue holds each branch's expected outcome/target/count, and a monitor checks resolutions.
module tb_branch_sequencer;
    localparam int FLUSH_CYCLES = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    logic       cmp_res;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_count = 16'd0;
    // {taken, target, taken_count after resolution}
    logic [32:0] exp_q[$];
    logic [15:0] pend_q[$];
    int          flush_run = 0;

    branch_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bif ();

    branch_sequencer #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (16),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bif      (bif),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: 6/7 unconditional, bit0=0 equal, bit0=1 unsigned less-than
    always_comb begin
        if (bif.cmp_opcode >= 3'd6) cmp_res = 1'b1;
        else if (bif.cmp_opcode[0]) cmp_res = (bif.cmp_first < bif.cmp_second);
        else cmp_res = (bif.cmp_first == bif.cmp_second);
    end
    assign bif.cmp_result = cmp_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_br_ready"}, bif.br_ready, 1);
        check({tag, "_resolved"}, bif.resolved, 0);
        check({tag, "_taken"}, bif.taken, 0);
        check({tag, "_redirect_valid"}, bif.redirect_valid, 0);
        check({tag, "_redirect_pc"}, bif.redirect_pc, 0);
        check({tag, "_flush"}, bif.flush, 0);
        check({tag, "_taken_count"}, bif.taken_count, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // Driver: called just after a negedge; returns at the negedge following acceptance
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pc, input logic [15:0] off,
                         input logic exp_tk, input logic [15:0] exp_tgt, input bit hold);
        int waited = 0;
        bif.br_valid  = 1'b1;
        bif.br_opcode = op;
        bif.br_first  = a;
        bif.br_second = b;
        bif.br_pc     = pc;
        bif.br_offset = off;
        while (!bif.br_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bif.br_ready) begin
            check("accept_timeout", bif.br_ready, 1);
            bif.br_valid = 1'b0;
            return;
        end
        if (exp_tk) model_count = model_count + 16'd1;
        exp_q.push_back({exp_tk, exp_tgt, model_count});
        @(negedge clk);
        if (!hold) bif.br_valid = 1'b0;
    endtask

    task automatic expect_ready_after(input string name, input int exp_cycles);
        int n = 0;
        while (!bif.br_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        model_count = 16'd0;
    endtask

    // Monitor / scoreboard
    always begin
        logic [32:0] e;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            pend_q.delete();
            flush_run = 0;
        end else begin
            if (bif.resolved) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resolved_unexpected: got resolved=1 expected no branch at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("taken", bif.taken, e[32]);
                    check("taken_count", bif.taken_count, e[15:0]);
                    if (e[32]) pend_q.push_back(e[31:16]);
                end
            end
            if (bif.redirect_valid) begin
                if (pend_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL redirect_unexpected: got redirect_valid=1 expected 0 at %0t", $time);
                end else begin
                    check("redirect_pc", bif.redirect_pc, pend_q[0]);
                    if (bif.fetch_ready) void'(pend_q.pop_front());
                end
            end
            if (bif.flush) begin
                flush_run++;
            end else if (flush_run != 0) begin
                check("flush_len", flush_run, FLUSH_CYCLES);
                flush_run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bif.br_valid    = 1'b0;
        bif.br_opcode   = 3'd0;
        bif.br_first    = 16'd0;
        bif.br_second   = 16'd0;
        bif.br_pc       = 16'd0;
        bif.br_offset   = 16'd0;
        bif.fetch_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_cmp_first", bif.cmp_first, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Not taken; fetch_ready high outside REDIRECT must do nothing
        bif.fetch_ready = 1'b1;
        issue(3'd0, 16'h1234, 16'h1235, 16'h0040, 16'h0008, 1'b0, 16'h0000, 1'b0);
        check("nt_busy", bif.br_ready, 0);
        check("nt_state_eval", state_dbg, 1);
        check("nt_cmp_first", bif.cmp_first, 16'h1234);
        check("nt_cmp_second", bif.cmp_second, 16'h1235);
        expect_ready_after("nt_ready", 1);
        check("nt_no_redirect", bif.redirect_valid, 0);
        check("nt_no_flush", bif.flush, 0);
        check("nt_count", bif.taken_count, 0);
        @(negedge clk);

        // Taken, PC-relative target wraps past 0xFFFF
        issue(3'd1, 16'h0003, 16'h0007, 16'hFFF0, 16'h0020, 1'b1, 16'h0010, 1'b0);
        @(negedge clk);
        check("tw_redirect_valid", bif.redirect_valid, 1);
        check("tw_resolved", bif.resolved, 1);
        expect_ready_after("tw_ready", 3);
        check("tw_count", bif.taken_count, 1);

        // Redirect stalled by fetch for 5 cycles
        bif.fetch_ready = 1'b0;
        issue(3'd6, 16'h0005, 16'h0002, 16'h0100, 16'hFFFC, 1'b1, 16'h00FC, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("st_redirect_valid", bif.redirect_valid, 1);
            check("st_redirect_pc", bif.redirect_pc, 16'h00FC);
            check("st_no_flush", bif.flush, 0);
            @(negedge clk);
        end
        bif.fetch_ready = 1'b1;
        check("st_last_valid", bif.redirect_valid, 1);
        @(negedge clk);
        check("st_flush_on", bif.flush, 1);
        check("st_redirect_dropped", bif.redirect_valid, 0);
        expect_ready_after("st_ready", 2);

        // Register jump ignores PC/offset
        issue(3'd7, 16'hBEEF, 16'h0000, 16'h1234, 16'h0004, 1'b1, 16'hBEEF, 1'b0);
        expect_ready_after("jr_ready", 4);

        // Equal-taken, unsigned compare boundaries
        issue(3'd0, 16'h55AA, 16'h55AA, 16'h0200, 16'h0010, 1'b1, 16'h0210, 1'b0);
        expect_ready_after("eq_ready", 4);
        issue(3'd1, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_ready_after("ltu_nt_ready", 1);
        @(negedge clk);
        issue(3'd1, 16'h0001, 16'h8000, 16'h0ABC, 16'hFFFF, 1'b1, 16'h0ABB, 1'b0);
        expect_ready_after("ltu_t_ready", 4);
        check("count_five", bif.taken_count, 5);

        // Back-to-back: br_valid held high across a not-taken branch
        issue(3'd0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
        bif.br_opcode = 3'd3;
        bif.br_first  = 16'h000A;
        bif.br_second = 16'h0004;
        exp_q.push_back({1'b0, 16'h0000, model_count});
        check("b2b_busy", bif.br_ready, 0);
        @(negedge clk);
        check("b2b_ready", bif.br_ready, 1);
        @(negedge clk);
        bif.br_valid = 1'b0;
        check("b2b_state_eval", state_dbg, 1);
        check("b2b_cmp_first", bif.cmp_first, 16'h000A);
        check("b2b_cmp_opcode", bif.cmp_opcode, 3);
        expect_ready_after("b2b_second_ready", 1);
        @(negedge clk);

        // Reset while a redirect is pending
        bif.fetch_ready = 1'b0;
        issue(3'd6, 16'h0000, 16'h0000, 16'h0300, 16'h0004, 1'b1, 16'h0304, 1'b0);
        @(negedge clk);
        check("rr_in_redirect", state_dbg, 2);
        pulse_reset("rst_redirect");

        // Reset during flush; the next request lands on the first edge after release
        bif.fetch_ready = 1'b1;
        issue(3'd6, 16'h0000, 16'h0000, 16'h0400, 16'h0010, 1'b1, 16'h0410, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rf_flush_on", bif.flush, 1);
        pulse_reset("rst_flush");
        issue(3'd0, 16'h0009, 16'h0009, 16'h0000, 16'h0008, 1'b1, 16'h0008, 1'b0);
        expect_ready_after("post_rst_ready", 4);
        check("post_rst_count", bif.taken_count, 1);

        // Taken counter wraps modulo 2^16
        force dut.taken_count_q = 16'hFFFF;
        model_count = 16'hFFFF;
        @(negedge clk);
        release dut.taken_count_q;
        issue(3'd6, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 1'b1, 16'h0020, 1'b0);
        expect_ready_after("wrap_ready", 4);
        check("wrap_count", bif.taken_count, 0);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("redirects_drained", pend_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
